mxm_operand_sequencer: RTL and testbench
========================================

Name: mxm_operand_sequencer

Overview:
- Upstream feeder for the MxM dot-product core.
- Buffers the operand matrices A (MxN, row-major, address m*N+n) and X (PxN, column-per-row, address p*N+n) in internal register arrays loaded through a write port.
- On start, streams one A/X element pair per accepted beat in p-outer, m-middle, n-inner order, with framing strobes that mark each N-length dot product.

Parameters:
- W, 8, element bit-width
- M, 10, rows of A / rows of result
- N, 8, inner dimension (dot-product length)
- P, 6, columns of result
- AW, $clog2(max(M*N,N*P)), write address width (derived, do not override)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = write A buffer, 1 = write X buffer
- wr_addr  in  AW  element address within selected buffer
- wr_data  in  W  element value
- start  in  1  begin streaming (level-sampled in IDLE)
- ready  in  1  downstream accepts current beat
- A  out  W  A operand, A_buf[m*N+n]
- X  out  W  X operand, X_buf[p*N+n]
- op_valid  out  1  A/X hold a valid beat
- op_first  out  1  beat has n==0
- op_last  out  1  beat has n==N-1
- m_idx  out  $clog2(M)  row index of current beat
- p_idx  out  $clog2(P)  column index of current beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final beat accepted
- wr_err  out  1  one-cycle pulse on rejected write

Behaviour:
- Reset (rst=0, async): state=IDLE; counters n,m,p=0; A, X, m_idx, p_idx = 0; op_valid, op_first, op_last, busy, done, wr_err = 0. Buffer contents are not reset (undefined until written).
- States: IDLE, STREAM.
- IDLE:
  - Accepts writes. Write occurs at the edge with wr_en=1.
  - Out-of-range address (>= M*N for A, >= N*P for X) is ignored and pulses wr_err the next cycle.
  - start=1 at edge k moves to STREAM. At edge k the output registers load beat (0,0,0): A=A_buf[0], X=X_buf[0], op_valid=1, op_first=1, busy=1.
- STREAM:
  - A beat is consumed at an edge with op_valid&ready. On consumption, outputs load the next beat the same edge (zero-bubble, one beat per cycle at ready=1).
  - ready=0: all outputs and counters hold.
  - Order: n increments; n wraps N-1 to 0 and increments m; m wraps M-1 to 0 and increments p.
  - op_first = (n==0); op_last = (n==N-1); both are registered with the beat.
- Final beat (n=N-1, m=M-1, p=P-1) consumed at edge e: op_valid=0, busy=0, counters=0, state=IDLE. done=1 for exactly the cycle after e.
- Total valid beats per run: M*N*P. With ready tied high, done asserts M*N*P+1 cycles after start is sampled.
- start while STREAM: ignored.
- Writes while busy: rejected, buffer unchanged, wr_err pulses one cycle.
- Async reset mid-stream: immediate return to reset values; no done pulse.
- Operands are passed unmodified; no arithmetic on data.

Optional Feature:
- Macro MXM_SEQ_REPEAT_EN.
- Defined: if start=1 at the edge that consumes the final beat, streaming restarts at (0,0,0) on that same edge with no bubble. done still pulses, busy stays 1. Otherwise behaviour is as below.
- Undefined: the final beat always returns to IDLE. A new run needs start sampled in IDLE, giving at least one idle cycle between runs.

Test Plan:
- Load A[i]=i, X[i]=0x80+i; start with ready=1 -> beat sequence (A,X) = (0,0x80),(1,0x81)..(7,0x87),(8,0x80)...; op_first every 8th beat starting at beat 0; done exactly 481 cycles after start sampled.
- Same load, ready toggling 1,0,1,0 -> beats and values identical to ready=1 run; outputs hold during ready=0; done after 480 accepted beats.
- Write with wr_addr=80, wr_sel=0 -> wr_err pulse, A_buf unchanged. Write during STREAM at address 3 -> wr_err pulse, streamed A[3] still equals the old value.
- Assert rst=0 at beat 200 -> op_valid, busy, A, X go to 0 immediately with no clock edge; no done pulse. Restart -> first beat is (0,0,0).
- start pulse during STREAM -> no effect; beat count stays 480.
- MXM_SEQ_REPEAT_EN defined, start held high -> beat 480 is (A[0],X[0]) with op_first=1 on the cycle after beat 479; done pulses once per 480 beats; busy never drops.

Source files
------------

// File: rtl/mxm_operand_sequencer.sv
// Purpose: buffers operand matrices A (MxN) and X (PxN) and streams A/X element pairs p-outer, m-middle, n-inner for the MxM dot-product core.
// Latency: first beat is registered on the edge that samples start; one beat per cycle after that; done pulses the cycle after the final beat is consumed.
// Backpressure: ready=0 freezes every output and counter; buffer writes are rejected (wr_err pulse) while streaming.
// Optional feature macro: MXM_SEQ_REPEAT_EN (start high on the final beat restarts at (0,0,0) with no bubble).
module mxm_operand_sequencer #(
  parameter int W = 8,
  parameter int M = 10,
  parameter int N = 8,
  parameter int P = 6,
  localparam int AW = $clog2((M*N > N*P) ? M*N : N*P),
  localparam int MW = (M > 1) ? $clog2(M) : 1,
  localparam int PW = (P > 1) ? $clog2(P) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic          i_wr_sel,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_start,
  input  logic          i_ready,
  output logic [W-1:0]  o_a,
  output logic [W-1:0]  o_x,
  output logic          o_op_valid,
  output logic          o_op_first,
  output logic          o_op_last,
  output logic [MW-1:0] o_m_idx,
  output logic [PW-1:0] o_p_idx,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_wr_err
);

  localparam int NW  = (N > 1) ? $clog2(N) : 1;
  localparam int AAW = (M*N > 1) ? $clog2(M*N) : 1;
  localparam int XAW = (N*P > 1) ? $clog2(N*P) : 1;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t        r_state;
  logic [NW-1:0] r_n;
  logic [MW-1:0] r_m;
  logic [PW-1:0] r_p;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_x;
  logic          r_op_valid;
  logic          r_op_first;
  logic          r_op_last;
  logic          r_busy;
  logic          r_done;
  logic          r_wr_err;

  // Operand storage; contents are only meaningful once written.
  logic [W-1:0]  r_a_buf [0:M*N-1];
  logic [W-1:0]  r_x_buf [0:N*P-1];

  logic           w_accept;
  logic           w_last_n;
  logic           w_last_m;
  logic           w_last_p;
  logic           w_final;
  logic           w_restart;
  logic           w_load;
  logic [NW-1:0]  w_tgt_n;
  logic [MW-1:0]  w_tgt_m;
  logic [PW-1:0]  w_tgt_p;
  logic [AAW-1:0] w_a_raddr;
  logic [XAW-1:0] w_x_raddr;
  logic           w_wr_oor;
  logic           w_wr_ok;

  assign w_accept = (r_state == S_STREAM) && r_op_valid && i_ready;
  assign w_last_n = (r_n == NW'(N-1));
  assign w_last_m = (r_m == MW'(M-1));
  assign w_last_p = (r_p == PW'(P-1));
  assign w_final  = w_last_n && w_last_m && w_last_p;

`ifdef MXM_SEQ_REPEAT_EN
  assign w_restart = i_start;
`else
  assign w_restart = 1'b0;
`endif

  // A new beat is loaded on start in IDLE, or on any consumed beat that is not the end of the run.
  assign w_load = ((r_state == S_IDLE) && i_start) ||
                  (w_accept && (!w_final || w_restart));

  // Indices of the beat to present next: (0,0,0) from IDLE or after the final beat, else n/m/p increment.
  always_comb begin
    w_tgt_n = '0;
    w_tgt_m = '0;
    w_tgt_p = '0;
    if ((r_state == S_STREAM) && !w_final) begin
      if (!w_last_n) begin
        w_tgt_n = r_n + 1'b1;
        w_tgt_m = r_m;
        w_tgt_p = r_p;
      end else if (!w_last_m) begin
        w_tgt_m = r_m + 1'b1;
        w_tgt_p = r_p;
      end else begin
        w_tgt_p = r_p + 1'b1;
      end
    end
  end

  assign w_a_raddr = AAW'(w_tgt_m) * AAW'(N) + AAW'(w_tgt_n);
  assign w_x_raddr = XAW'(w_tgt_p) * XAW'(N) + XAW'(w_tgt_n);

  // Range check done at 32 bits so a buffer that exactly fills the address space still compares correctly.
  assign w_wr_oor = i_wr_sel ? (32'(i_wr_addr) >= N*P) : (32'(i_wr_addr) >= M*N);
  assign w_wr_ok  = i_wr_en && (r_state == S_IDLE) && !w_wr_oor;

  // Buffer write port: only in-range writes while idle land in storage.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && !i_wr_sel) r_a_buf[i_wr_addr[AAW-1:0]] <= i_wr_data;
    if (w_wr_ok &&  i_wr_sel) r_x_buf[i_wr_addr[XAW-1:0]] <= i_wr_data;
  end

  // Sequencer FSM with registered beat outputs, done and write-error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_m        <= '0;
      r_p        <= '0;
      r_a        <= '0;
      r_x        <= '0;
      r_op_valid <= 1'b0;
      r_op_first <= 1'b0;
      r_op_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_done   <= w_accept && w_final;
      r_wr_err <= i_wr_en && ((r_state != S_IDLE) || w_wr_oor);
      if (w_load) begin
        r_state    <= S_STREAM;
        r_busy     <= 1'b1;
        r_op_valid <= 1'b1;
        r_n        <= w_tgt_n;
        r_m        <= w_tgt_m;
        r_p        <= w_tgt_p;
        r_a        <= r_a_buf[w_a_raddr];
        r_x        <= r_x_buf[w_x_raddr];
        r_op_first <= (w_tgt_n == '0);
        r_op_last  <= (w_tgt_n == NW'(N-1));
      end else if (w_accept) begin
        // Final beat consumed with no restart: back to IDLE, A/X keep the last operands.
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_op_valid <= 1'b0;
        r_op_first <= 1'b0;
        r_op_last  <= 1'b0;
        r_n        <= '0;
        r_m        <= '0;
        r_p        <= '0;
      end
    end
  end

  assign o_a        = r_a;
  assign o_x        = r_x;
  assign o_op_valid = r_op_valid;
  assign o_op_first = r_op_first;
  assign o_op_last  = r_op_last;
  assign o_m_idx    = r_m;
  assign o_p_idx    = r_p;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_wr_err   = r_wr_err;

endmodule

// File: tb/tb_mxm_operand_sequencer.sv
// Bench for mxm_operand_sequencer: expected beats come from a queue built by nested p/m/n loops over model buffers.
// Outputs are observed on the falling edge; inputs change on the falling edge.
// Optional repeat mode is exercised when MXM_SEQ_REPEAT_EN is defined.
module tb_mxm_operand_sequencer;

  localparam int W  = 8;
  localparam int M  = 10;
  localparam int N  = 8;
  localparam int P  = 6;
  localparam int AW = $clog2((M*N > N*P) ? M*N : N*P);
  localparam int NB = M*N*P;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] x;
    bit           first;
    bit           last;
    int           m;
    int           p;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          start;
  logic          ready;
  logic [W-1:0]  a;
  logic [W-1:0]  x;
  logic          op_valid;
  logic          op_first;
  logic          op_last;
  logic [3:0]    m_idx;
  logic [2:0]    p_idx;
  logic          busy;
  logic          done;
  logic          wr_err;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] mdl_a [M*N];
  logic [W-1:0] mdl_x [N*P];
  beat_t        exp_q [$];

  mxm_operand_sequencer #(.W(W), .M(M), .N(N), .P(P)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_sel   (wr_sel),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_start    (start),
    .i_ready    (ready),
    .o_a        (a),
    .o_x        (x),
    .o_op_valid (op_valid),
    .o_op_first (op_first),
    .o_op_last  (op_last),
    .o_m_idx    (m_idx),
    .o_p_idx    (p_idx),
    .o_busy     (busy),
    .o_done     (done),
    .o_wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, op_valid, 0);
    chk({tag, "_first"}, op_first, 0);
    chk({tag, "_last"},  op_last,  0);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_done"},  done,     0);
    chk({tag, "_werr"},  wr_err,   0);
    chk({tag, "_a"},     a,        0);
    chk({tag, "_x"},     x,        0);
    chk({tag, "_m"},     m_idx,    0);
    chk({tag, "_p"},     p_idx,    0);
  endtask

  // One write cycle; the model buffer changes only when the write is expected to be accepted.
  task automatic wr(input bit sel, input int addr, input logic [W-1:0] d, input bit exp_err);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    chk("wr_err", wr_err, 32'(exp_err));
    if (!exp_err) begin
      if (sel) mdl_x[addr] = d;
      else     mdl_a[addr] = d;
    end
  endtask

  // Expected run: every dot product of result column p, row m walks n across both operands.
  function automatic void build_run();
    for (int p = 0; p < P; p++)
      for (int m = 0; m < M; m++)
        for (int n = 0; n < N; n++) begin
          beat_t b;
          b.a     = mdl_a[m*N + n];
          b.x     = mdl_x[p*N + n];
          b.first = (n == 0);
          b.last  = (n == N-1);
          b.m     = m;
          b.p     = p;
          exp_q.push_back(b);
        end
  endfunction

  // rmode: 0 ready high, 1 ready alternating, 2 ready random with stray start pulses.
  task automatic run_stream(input int rmode, input int abort_at, input int runs, input int probe_at);
    int acc = 0;
    int cyc = 0;
    int dones = 0;
    bit pend_done = 0;
    bit exp_werr = 0;
    bit probed = 0;
    bit fin = 0;
    bit r;
    for (int k = 0; k < runs; k++) build_run();
    start = 1'b1;
    while (!fin && cyc < 3000*runs) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      wr_en = 1'b0;
      chk("done", done, 32'(pend_done));
      if (pend_done) begin
        dones++;
        if (rmode == 0) chk("done_lat", cyc, acc + 1);
      end
      pend_done = 0;
      chk("wr_err_run", wr_err, 32'(exp_werr));
      exp_werr = 0;
      if (exp_q.size() == 0) begin
        chk("end_valid", op_valid, 0);
        chk("end_busy", busy, 0);
        fin = 1;
      end else begin
        chk("valid", op_valid, 1);
        chk("busy",  busy, 1);
        chk("a",     a, exp_q[0].a);
        chk("x",     x, exp_q[0].x);
        chk("first", op_first, 32'(exp_q[0].first));
        chk("last",  op_last, 32'(exp_q[0].last));
        chk("m_idx", m_idx, exp_q[0].m);
        chk("p_idx", p_idx, exp_q[0].p);
        if (acc == abort_at) begin
          start = 1'b0;
          ready = 1'b0;
          rst_n = 1'b0;
          #1;
          chk_zero("abort");
          #1 rst_n = 1'b1;
          exp_q.delete();
          repeat (3) begin
            @(negedge clk);
            chk("abort_done", done, 0);
            chk("abort_busy", busy, 0);
            chk("abort_valid", op_valid, 0);
          end
          return;
        end
        case (rmode)
          0:       r = 1'b1;
          1:       r = cyc[0];
          default: r = ($urandom % 3) != 0;
        endcase
        ready = r;
        if (runs > 1) start = exp_q.size() > NB;
        else          start = (rmode == 2) && (exp_q.size() > 1) && (($urandom % 16) == 0);
        if (acc == probe_at && !probed) begin
          wr_en    = 1'b1;
          wr_sel   = 1'b0;
          wr_addr  = AW'(3);
          wr_data  = ~mdl_a[3];
          exp_werr = 1;
          probed   = 1;
        end
        if (r) begin
          void'(exp_q.pop_front());
          acc++;
          if (acc % NB == 0) pend_done = 1;
        end
      end
    end
    chk("finished", 32'(fin), 1);
    chk("beats", acc, NB*runs);
    chk("n_done", dones, runs);
    start = 1'b0;
    ready = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    ready   = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");

    for (int i = 0; i < M*N; i++) wr(1'b0, i, W'(i), 1'b0);
    for (int i = 0; i < N*P; i++) wr(1'b1, i, W'(8'h80 + i), 1'b0);
    wr(1'b0, M*N, 8'h55, 1'b1);
    wr(1'b1, N*P, 8'h55, 1'b1);
    wr(1'b0, 127, 8'h66, 1'b1);
    @(negedge clk);
    chk("wr_err_clear", wr_err, 0);

    run_stream(0, -1, 1, -1);
    run_stream(1, -1, 1, -1);
    run_stream(2, -1, 1, 25);

    for (int i = 0; i < M*N; i++) wr(1'b0, i, W'($urandom), 1'b0);
    for (int i = 0; i < N*P; i++) wr(1'b1, i, W'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) begin
      wr(1'b0, $urandom_range(M*N, 127), W'($urandom), 1'b1);
      wr(1'b1, $urandom_range(N*P, 127), W'($urandom), 1'b1);
    end

    run_stream(2, -1, 1, -1);
    run_stream(0, 200, 1, -1);
    run_stream(2, -1, 1, 7);
`ifdef MXM_SEQ_REPEAT_EN
    run_stream(0, -1, 2, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
